servo_pwm_decoder: RTL and testbench

SERVO_PWM_DECODER -- requirements
Module: servo_pwm_decoder

---
 rtl/servo_pwm_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_servo_pwm_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_decoder.sv
// RC servo pulse decoder: measures high time and rise-to-rise period of pwm_in,
// validates each frame and converts the width into a position with a serial divider.
module servo_pwm_decoder #(
  parameter int MIN_W     = 400,
  parameter int STEP      = 10,
  parameter int MAX_POS   = 220,
  parameter int FRAME_MIN = 15000,
  parameter int FRAME_MAX = 25000,
  parameter int TIMEOUT   = 25000
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        pwm_in,
  output logic [7:0]  pos,
  output logic        pos_valid,
  output logic [14:0] width,
  output logic [14:0] period,
  output logic        link_ok,
  output logic        err_range,
  output logic        err_timeout,
  output logic [15:0] data_out,
  output logic [1:0]  state_dbg
);

  localparam int          MAX_W     = MIN_W + STEP * MAX_POS;
  localparam logic [14:0] MIN_W_C   = 15'(MIN_W);
  localparam logic [14:0] MAX_W_C   = 15'(MAX_W);
  localparam logic [14:0] STEP_C    = 15'(STEP);
  localparam logic [14:0] FMIN_C    = 15'(FRAME_MIN);
  localparam logic [14:0] FMAX_C    = 15'(FRAME_MAX);
  localparam logic [14:0] TMO_C     = 15'(TIMEOUT);
  localparam logic [14:0] CNT_SAT   = 15'h7fff;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        sync1, sync2, sync_d;
  logic        rise, fall;
  logic [14:0] cnt;
  logic [14:0] width_hold;
  logic        cnt_restart, fall_latch, frame_close, tmo;
  logic        frame_legal, accept, reject;
  logic        div_busy, div_done;
  logic [14:0] div_rem;
  logic [7:0]  div_q;
  logic        dir;

  // Two flops to resolve metastability, a third to find edges.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // An edge in the same cycle as the timeout count wins, so a period of
  // exactly TIMEOUT clocks still closes a frame.
  always_comb begin
    state_nxt   = state;
    cnt_restart = 1'b0;
    fall_latch  = 1'b0;
    frame_close = 1'b0;
    tmo         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt   = ST_HIGH;
          cnt_restart = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_nxt  = ST_LOW;
          fall_latch = 1'b1;
        end else if (cnt == TMO_C) begin
          state_nxt = ST_IDLE;
          tmo       = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_nxt   = ST_HIGH;
          frame_close = 1'b1;
          cnt_restart = 1'b1;
        end else if (cnt == TMO_C) begin
          state_nxt = ST_IDLE;
          tmo       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign state_dbg = state;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_restart) begin
      cnt <= 15'd1;
    end else if (tmo || state == ST_IDLE) begin
      cnt <= '0;
    end else if (cnt != CNT_SAT) begin
      cnt <= cnt + 15'd1;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) width_hold <= '0;
    else if (fall_latch) width_hold <= cnt;
  end

  assign frame_legal = (width_hold >= MIN_W_C) && (width_hold <= MAX_W_C) &&
                       (cnt >= FMIN_C) && (cnt <= FMAX_C);
  assign accept      = frame_close & frame_legal;
  assign reject      = frame_close & ~frame_legal;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      width  <= '0;
      period <= '0;
    end else if (frame_close) begin
      width  <= width_hold;
      period <= cnt;
    end
  end

  // Quotient by repeated subtraction; a new accepted frame or a timeout aborts.
  assign div_done = div_busy & (div_rem < STEP_C) & ~accept & ~tmo;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      div_rem  <= '0;
      div_q    <= '0;
    end else if (accept) begin
      div_busy <= 1'b1;
      div_rem  <= width_hold - MIN_W_C;
      div_q    <= '0;
    end else if (tmo) begin
      div_busy <= 1'b0;
    end else if (div_busy) begin
      if (div_rem < STEP_C) begin
        div_busy <= 1'b0;
      end else begin
        div_rem <= div_rem - STEP_C;
        div_q   <= div_q + 8'd1;
      end
    end
  end

  // pos_valid is a single-cycle strobe with no back-pressure: pos is stable
  // from that cycle until the next strobe.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      pos_valid <= 1'b0;
      dir       <= 1'b0;
    end else begin
      pos_valid <= div_done;
      if (div_done) begin
        pos <= div_q;
        dir <= (div_q > pos);
      end
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      link_ok     <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (reject || tmo)  link_ok <= 1'b0;
      else if (div_done)  link_ok <= 1'b1;
      if (reject)         err_range <= 1'b1;
      else if (div_done)  err_range <= 1'b0;
      if (tmo)            err_timeout <= 1'b1;
      else if (div_done)  err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 16'h4000;
    end else begin
      data_out <= {2'b01, 2'b00, pos[7:4], 2'b00, pos[3:0], dir,
                   err_range | err_timeout};
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder: event-time model of frame decoding compared every
// cycle, plus literal checkpoints. Frame timing limits are scaled down to keep runs short.
module tb_servo_pwm_decoder;

  localparam int MIN_W = 400;
  localparam int STEP  = 10;
  localparam int MAX_W = 2600;
  localparam int FMIN  = 3000;
  localparam int FMAX  = 4000;
  localparam int TMO   = 4000;
  localparam int SYNC_LAT = 3;

  typedef struct {
    int   t;
    logic lvl;
  } tr_t;

  logic        mclk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [7:0]  pos;
  logic        pos_valid;
  logic [14:0] width;
  logic [14:0] period;
  logic        link_ok;
  logic        err_range;
  logic        err_timeout;
  logic [15:0] data_out;
  logic [1:0]  state_dbg;

  servo_pwm_decoder #(
    .MIN_W(MIN_W), .STEP(STEP), .MAX_POS(220),
    .FRAME_MIN(FMIN), .FRAME_MAX(FMAX), .TIMEOUT(TMO)
  ) dut (
    .mclk(mclk), .rst_n(rst_n), .pwm_in(pwm_in),
    .pos(pos), .pos_valid(pos_valid), .width(width), .period(period),
    .link_ok(link_ok), .err_range(err_range), .err_timeout(err_timeout),
    .data_out(data_out), .state_dbg(state_dbg)
  );

  // ---------------- clock / edge counter ----------------
  always #5 mclk = ~mclk;

  int n_edge = 0;
  always @(posedge mclk) n_edge <= n_edge + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  tr_t tr_q[$];
  tr_t tr;
  int  m_state, t_open, m_wh, m_width, m_period, m_pos, m_dir;
  int  m_er, m_et, m_link, m_pv, div_pend, div_q, div_t, per, n;
  logic [15:0] data_prev, exp_data;
  int  pv_cnt = 0, last_pv_edge = 0, et_rise_edge = 0, rise_e = 0, pv_snap = 0;
  logic et_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  function automatic logic [15:0] word(input int p, input int d, input int e);
    logic [7:0] pb;
    pb = 8'(p);
    return {2'b01, 2'b00, pb[7:4], 2'b00, pb[3:0], (d != 0), (e != 0)};
  endfunction

  task automatic model_reset();
    tr_q.delete();
    m_state = 0; t_open = 0; m_wh = 0; m_width = 0; m_period = 0;
    m_pos = 0; m_dir = 0; m_er = 0; m_et = 0; m_link = 0; m_pv = 0;
    div_pend = 0; div_q = 0; div_t = 0;
    data_prev = 16'h4000;
  endtask

  // Model works on frame events: each input edge takes effect SYNC_LAT edges
  // after it is driven; outcomes follow from measured high time and period.
  always @(negedge mclk) begin
    n = n_edge;
    m_pv = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (div_pend != 0 && n == div_t) begin
        m_pv = 1;
        m_dir = (div_q > m_pos) ? 1 : 0;
        m_pos = div_q;
        m_link = 1; m_er = 0; m_et = 0;
        div_pend = 0;
      end
      if (tr_q.size() != 0 && tr_q[0].t == n) begin
        tr = tr_q.pop_front();
        if (tr.lvl) begin
          if (m_state == 0) begin
            m_state = 1; t_open = n;
          end else if (m_state == 2) begin
            per = n - t_open;
            m_period = per; m_width = m_wh;
            if (m_wh >= MIN_W && m_wh <= MAX_W && per >= FMIN && per <= FMAX) begin
              div_pend = 1;
              div_q = (m_wh - MIN_W) / STEP;
              div_t = n + 1 + div_q;
            end else begin
              m_er = 1; m_link = 0;
            end
            t_open = n; m_state = 1;
          end
        end else if (m_state == 1) begin
          m_wh = n - t_open; m_state = 2;
        end
      end else if (m_state != 0 && n - t_open == TMO) begin
        m_et = 1; m_link = 0; div_pend = 0; m_state = 0;
      end
    end
    exp_data = data_prev;
    check("pos",         32'(pos),         m_pos);
    check("pos_valid",   32'(pos_valid),   m_pv);
    check("width",       32'(width),       m_width);
    check("period",      32'(period),      m_period);
    check("link_ok",     32'(link_ok),     m_link);
    check("err_range",   32'(err_range),   m_er);
    check("err_timeout", 32'(err_timeout), m_et);
    check("state",       32'(state_dbg),   m_state);
    check("data_out",    32'(data_out),    32'(exp_data));
    data_prev = word(m_pos, m_dir, m_er | m_et);
    if (pos_valid) begin
      pv_cnt++;
      last_pv_edge = n;
    end
    if (err_timeout && !et_q) et_rise_edge = n;
    et_q = err_timeout;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic lvl);
    @(posedge mclk);
    #1;
    pwm_in = lvl;
    if (rst_n) tr_q.push_back('{n_edge + SYNC_LAT, lvl});
    if (lvl) rise_e = n_edge;
  endtask

  task automatic pulse(input int h, input int p);
    drive(1'b1);
    repeat (h - 1) @(posedge mclk);
    drive(1'b0);
    repeat (p - h - 1) @(posedge mclk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1;
    pwm_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (5) @(posedge mclk);
    @(negedge mclk);
    check("rst_data_out", 32'(data_out), 32'h4000);
    check("rst_pos",      32'(pos),      32'd0);
    @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge mclk);

    // Three 400-clock frames, closed by the next rise.
    for (int i = 0; i < 3; i++) pulse(400, 3200);
    pulse(1405, 3200);
    @(negedge mclk);
    check("a_pv_count", 32'(pv_cnt),   32'd3);
    check("a_pos",      32'(pos),      32'd0);
    check("a_width",    32'(width),    32'd400);
    check("a_period",   32'(period),   32'd3200);
    check("a_link",     32'(link_ok),  32'd1);
    check("a_data",     32'(data_out), 32'h4000);

    pulse(1405, 3200);
    @(negedge mclk);
    check("b_pos",     32'(pos),      32'd100);
    check("b_data",    32'(data_out), 32'h4612);
    check("b_latency", 32'(last_pv_edge - (rise_e + SYNC_LAT)), 32'd101);

    pulse(2600, 3200);
    pulse(2610, 3200);
    @(negedge mclk);
    check("c_pos",     32'(pos),      32'd220);
    check("c_data",    32'(data_out), 32'h4d32);
    check("c_latency", 32'(last_pv_edge - (rise_e + SYNC_LAT)), 32'd221);

    pulse(400, 3200);
    @(negedge mclk);
    check("d_err_range", 32'(err_range), 32'd1);
    check("d_link",      32'(link_ok),   32'd0);
    check("d_pos",       32'(pos),       32'd220);
    check("d_data",      32'(data_out),  32'h4d33);

    // Short period, then recovery.
    pulse(400, 2900);
    pulse(400, 3200);
    @(negedge mclk);
    check("s_err_range", 32'(err_range),   32'd1);
    check("s_period",    32'(period),      32'd2900);
    check("s_err_tmo",   32'(err_timeout), 32'd0);
    pulse(400, 3200);
    @(negedge mclk);
    check("s_cleared", 32'(err_range), 32'd0);
    check("s_link",    32'(link_ok),   32'd1);

    // Period one past the limit times out in LOW.
    pulse(400, TMO + 1);
    pulse(400, 3200);
    @(negedge mclk);
    check("l_err_tmo",   32'(err_timeout), 32'd1);
    check("l_err_range", 32'(err_range),   32'd0);
    check("l_link",      32'(link_ok),     32'd0);

    // pwm_in stuck high.
    drive(1'b1);
    repeat (4999) @(posedge mclk);
    @(negedge mclk);
    check("h_tmo_delay", 32'(et_rise_edge - (rise_e + SYNC_LAT)), 32'(TMO));
    check("h_err_tmo",   32'(err_timeout), 32'd1);
    check("h_state",     32'(state_dbg),   32'd0);
    check("h_link",      32'(link_ok),     32'd0);
    drive(1'b0);
    repeat (999) @(posedge mclk);
    pulse(400, 3200);
    pulse(400, 3200);
    @(negedge mclk);
    check("h_cleared", 32'(err_timeout), 32'd0);
    check("h_relink",  32'(link_ok),     32'd1);

    // Reset in the middle of a 2600-clock divide.
    pulse(2600, 3200);
    drive(1'b1);
    repeat (100) @(posedge mclk);
    pv_snap = pv_cnt;
    @(posedge mclk);
    #1;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (4) @(posedge mclk);
    @(negedge mclk);
    check("r_pos",    32'(pos),         32'd0);
    check("r_width",  32'(width),       32'd0);
    check("r_period", 32'(period),      32'd0);
    check("r_link",   32'(link_ok),     32'd0);
    check("r_errs",   32'({err_range, err_timeout}), 32'd0);
    check("r_data",   32'(data_out),    32'h4000);
    @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge mclk);
    @(negedge mclk);
    check("r_no_pv",     32'(pv_cnt),   32'(pv_snap));
    check("r_pos_after", 32'(pos),      32'd0);
    check("r_data_after", 32'(data_out), 32'h4000);

    // Decoding resumes from IDLE.
    pulse(400, 3200);
    pulse(400, 3200);
    @(negedge mclk);
    check("z_link",   32'(link_ok), 32'd1);
    check("z_width",  32'(width),   32'd400);
    check("z_period", 32'(period),  32'd3200);
    repeat (10) @(posedge mclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
